envelope_generator: RTL and testbench
=====================================

ENVELOPE_GENERATOR -- requirements
Module: envelope_generator

Interface
REQ-001 The block SHALL have parameter ATTACK_STEP, default 16'd4096, meaning level increment per sample tick in ATTACK.
REQ-002 The block SHALL have parameter DECAY_STEP, default 16'd1024, meaning level decrement per sample tick in DECAY.
REQ-003 The block SHALL have parameter SUSTAIN_LEVEL, default 16'd32768, meaning the level held in SUSTAIN.
REQ-004 The block SHALL have parameter RELEASE_STEP, default 16'd2048, meaning level decrement per sample tick in RELEASE.
REQ-005 The block SHALL have port clk_in, input, 1 bit: 100 MHz system clock, the only clock.
REQ-006 The block SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port sample_tick, input, 1 bit: one-cycle strobe at the audio sample rate (16,384 Hz).
REQ-008 The block SHALL have port gate_in, input, 1 bit: note held, from the note decoder.
REQ-009 The block SHALL have port trigger_in, input, 1 bit: one-cycle note-on pulse, from the note decoder.
REQ-010 The block SHALL have port sample_in, input, 16 bits: signed two's-complement BRAM sample for the selected note.
REQ-011 The block SHALL have port sample_out, output, 16 bits: signed, envelope-scaled sample.
REQ-012 The block SHALL have port dc_out, output, 8 bits: unsigned PWM duty cycle for the 256-step PWM.
REQ-013 The block SHALL have port sample_valid_out, output, 1 bit: one-cycle pulse when sample_out and dc_out update.
REQ-014 The block SHALL have port env_level_out, output, 16 bits: unsigned current envelope level.
REQ-015 The block SHALL have port active_out, output, 1 bit: high when the state is not IDLE.

Function
REQ-016 The state machine SHALL have states IDLE, ATTACK, DECAY, SUSTAIN and RELEASE, and SHALL change state and level only on cycles where sample_tick=1.
REQ-017 A trigger_in pulse SHALL set a pending flag; the flag SHALL be cleared on the next sample_tick, which SHALL move the state to ATTACK from any state and SHALL NOT reset the level (retrigger starts from the current level).
REQ-018 A trigger_in pulse on the same cycle as sample_tick SHALL take effect on that tick.
REQ-019 In ATTACK, each tick SHALL compute level = min(level+ATTACK_STEP, 65535) with no wrap; reaching 65535 SHALL move the state to DECAY.
REQ-020 In DECAY, each tick SHALL compute level = max(level-DECAY_STEP, SUSTAIN_LEVEL); reaching SUSTAIN_LEVEL SHALL move the state to SUSTAIN.
REQ-021 In SUSTAIN, the level SHALL be held.
REQ-022 When a tick is taken with gate_in=0 in ATTACK, DECAY or SUSTAIN, the state SHALL move to RELEASE, with the level unchanged on that tick.
REQ-023 A pending trigger SHALL override gate_in=0 on the same tick.
REQ-024 In RELEASE, each tick SHALL compute level = max(level-RELEASE_STEP, 0); reaching 0 SHALL move the state to IDLE. A gate_in=1 level without a trigger SHALL NOT restart the envelope.
REQ-025 In IDLE, the level SHALL be 0.
REQ-026 Scaling SHALL be pipelined. If tick is at cycle T, the level is updated and visible at T+1. At T+1, sample_out SHALL be registered as bits [31:16] of the signed product of sample_in (sampled at T+1) and the zero-extended level. sample_out, dc_out and sample_valid_out SHALL be visible at T+2.
REQ-027 dc_out SHALL equal sample_out[15:8]+8'd128, modulo 256.
REQ-028 sample_valid_out SHALL pulse for exactly one cycle per tick.

Reset
REQ-029 While rst_in=1, the state SHALL be IDLE, level 0, pending flag 0, sample_out 0, dc_out 8'd128, sample_valid_out 0 and active_out 0.
REQ-030 Reset asserted mid-envelope SHALL abort it with no release tail; pipeline contents SHALL be discarded.

Structure
REQ-031 Package synth_pkg SHALL hold env_state_t (enumerated 3-bit) and constants ENV_WIDTH=16, SAMPLE_WIDTH=16 and DC_MID=8'd128.
REQ-032 Scaling SHALL be one sub-module, envelope_vca (a registered multiply plus DC offset); the state machine and level logic SHALL remain in envelope_generator.

Verification
REQ-033 Default parameters, trigger with gate=1 and sample_in=16'h4000: level SHALL reach 65535 on tick 16 (state DECAY), then SUSTAIN with level 32768 on tick 48, and sample_out SHALL settle at 16'h2000.
REQ-034 Gate dropped in SUSTAIN: RELEASE SHALL begin on the next tick, level SHALL reach 0 after 16 ticks with the state IDLE, and active_out SHALL be 0 with dc_out 128.
REQ-035 Retrigger in RELEASE at level 16384: the state SHALL become ATTACK, level 20480 one tick later with no drop to 0, and 65535 after 12 ticks.
REQ-036 Trigger, gate low and sample_tick asserted on the same cycle: the state SHALL become ATTACK, and RELEASE SHALL follow on the next tick.
REQ-037 rst_in asserted in DECAY: outputs SHALL take the REQ-029 values on the next cycle, and no sample_valid_out SHALL occur for the in-flight tick.
REQ-038 sample_in=16'h8000 at level 65535: sample_out SHALL be 16'h8000 (the product is bounded, so no overflow occurs), and dc_out SHALL be 8'd0.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and constants for the envelope generator and its VCA.
// No ports; imported by envelope_generator and envelope_vca.
package synth_pkg;

    localparam int ENV_WIDTH    = 16;
    localparam int SAMPLE_WIDTH = 16;

    // PWM duty cycle that corresponds to a zero-valued sample.
    localparam logic [7:0] DC_MID = 8'd128;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/envelope_vca.sv
// Voltage-controlled amplifier stage: scales a signed sample by the unsigned
// envelope level and derives the offset PWM duty cycle.
// Ports:
//   clk_i, rst_i  - clock, synchronous active-high reset
//   vld_i         - level_i is fresh this cycle; capture the scaled sample
//   sample_i      - signed sample
//   level_i       - unsigned envelope level (full scale 65535)
//   sample_o      - signed scaled sample, registered
//   dc_o          - sample_o[15:8] offset to mid-scale, registered
//   vld_o         - one-cycle pulse when sample_o / dc_o update
module envelope_vca
    import synth_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    vld_i,
    input  logic [SAMPLE_WIDTH-1:0] sample_i,
    input  logic [ENV_WIDTH-1:0]    level_i,
    output logic [SAMPLE_WIDTH-1:0] sample_o,
    output logic [7:0]              dc_o,
    output logic                    vld_o
);

    logic signed [32:0]             sample_ext_p0;
    logic signed [32:0]             level_ext_p0;
    logic signed [32:0]             prod_p0;
    logic signed [SAMPLE_WIDTH-1:0] scaled_p0;
    logic                           prod_unused;

    logic [SAMPLE_WIDTH-1:0] sample_q;
    logic [7:0]              dc_q;
    logic                    vld_q;

    // The level is zero-extended so it multiplies as a positive value. The
    // product magnitude stays below 2^31, so bits [31:16] never overflow.
    assign sample_ext_p0 = $signed({{17{sample_i[SAMPLE_WIDTH-1]}}, sample_i});
    assign level_ext_p0  = $signed({17'd0, level_i});
    assign prod_p0       = sample_ext_p0 * level_ext_p0;
    assign scaled_p0     = prod_p0[31:16];
    assign prod_unused   = ^{prod_p0[32], prod_p0[15:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_q <= '0;
            dc_q     <= DC_MID;
            vld_q    <= 1'b0;
        end else begin
            vld_q <= vld_i;
            if (vld_i) begin
                sample_q <= scaled_p0;
                dc_q     <= scaled_p0[15:8] + DC_MID;
            end
        end
    end

    assign sample_o = sample_q;
    assign dc_o     = dc_q;
    assign vld_o    = vld_q;

endmodule

// File: rtl/envelope_generator.sv
// ADSR envelope generator driving a VCA. All state and level changes happen
// on sample_tick; the scaled sample appears two cycles after the tick.
// Ports:
//   clk_in, rst_in    - 100 MHz clock, synchronous active-high reset
//   sample_tick       - one-cycle strobe at the audio sample rate
//   gate_in           - note held
//   trigger_in        - one-cycle note-on pulse
//   sample_in         - signed sample for the selected note
//   sample_out        - signed, envelope-scaled sample
//   dc_out            - PWM duty cycle (sample_out[15:8] + 128)
//   sample_valid_out  - one-cycle pulse when sample_out / dc_out update
//   env_level_out     - current envelope level
//   active_out        - envelope is not IDLE
module envelope_generator
    import synth_pkg::*;
#(
    parameter logic [15:0] ATTACK_STEP   = 16'd4096,
    parameter logic [15:0] DECAY_STEP    = 16'd1024,
    parameter logic [15:0] SUSTAIN_LEVEL = 16'd32768,
    parameter logic [15:0] RELEASE_STEP  = 16'd2048
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        sample_tick,
    input  logic        gate_in,
    input  logic        trigger_in,
    input  logic [15:0] sample_in,
    output logic [15:0] sample_out,
    output logic [7:0]  dc_out,
    output logic        sample_valid_out,
    output logic [15:0] env_level_out,
    output logic        active_out
);

    env_state_t           state_q, state_d;
    logic [ENV_WIDTH-1:0] level_q, level_d;
    logic                 pending_q, pending_d;
    logic                 vld_p0_q;

    function automatic logic [ENV_WIDTH-1:0] sat_add(
        input logic [ENV_WIDTH-1:0] a,
        input logic [ENV_WIDTH-1:0] b
    );
        logic [ENV_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ENV_WIDTH] ? '1 : s[ENV_WIDTH-1:0];
    endfunction

    // max(a - b, floor) without wrapping below zero.
    function automatic logic [ENV_WIDTH-1:0] sat_sub(
        input logic [ENV_WIDTH-1:0] a,
        input logic [ENV_WIDTH-1:0] b,
        input logic [ENV_WIDTH-1:0] floor
    );
        logic [ENV_WIDTH:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[ENV_WIDTH] || (d[ENV_WIDTH-1:0] < floor)) return floor;
        return d[ENV_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            level_q   <= '0;
            pending_q <= 1'b0;
            vld_p0_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            pending_q <= pending_d;
            vld_p0_q  <= sample_tick;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        pending_d = pending_q | trigger_in;
        if (sample_tick) begin
            pending_d = 1'b0;
            // A trigger (pending or arriving now) wins over everything,
            // including a dropped gate; the level carries over.
            if (pending_q || trigger_in) begin
                state_d = ST_ATTACK;
            end else begin
                case (state_q)
                    ST_ATTACK: begin
                        if (!gate_in) begin
                            state_d = ST_RELEASE;
                        end else begin
                            level_d = sat_add(level_q, ATTACK_STEP);
                            if (level_d == '1) state_d = ST_DECAY;
                        end
                    end
                    ST_DECAY: begin
                        if (!gate_in) begin
                            state_d = ST_RELEASE;
                        end else begin
                            level_d = sat_sub(level_q, DECAY_STEP, SUSTAIN_LEVEL);
                            if (level_d == SUSTAIN_LEVEL) state_d = ST_SUSTAIN;
                        end
                    end
                    ST_SUSTAIN: begin
                        if (!gate_in) state_d = ST_RELEASE;
                    end
                    ST_RELEASE: begin
                        level_d = sat_sub(level_q, RELEASE_STEP, '0);
                        if (level_d == '0) state_d = ST_IDLE;
                    end
                    ST_IDLE: begin
                        level_d = '0;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        level_d = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        active_out    = (state_q != ST_IDLE);
        env_level_out = level_q;
    end

    // vld_p0_q marks the cycle after a tick, when level_q holds the new level.
    envelope_vca u_vca (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .vld_i    (vld_p0_q),
        .sample_i (sample_in),
        .level_i  (level_q),
        .sample_o (sample_out),
        .dc_o     (dc_out),
        .vld_o    (sample_valid_out)
    );

endmodule

// File: tb/tb_envelope_generator.sv
module tb_envelope_generator;

    logic        clk = 1'b0;
    logic        rst, tick, gate, trig;
    logic [15:0] sin;
    logic [15:0] sout, lvl;
    logic [7:0]  dc;
    logic        svld, act;

    always #5 clk = ~clk;

    envelope_generator dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .sample_tick      (tick),
        .gate_in          (gate),
        .trigger_in       (trig),
        .sample_in        (sin),
        .sample_out       (sout),
        .dc_out           (dc),
        .sample_valid_out (svld),
        .env_level_out    (lvl),
        .active_out       (act)
    );

    localparam int A_STEP = 4096, D_STEP = 1024, SUS = 32768, R_STEP = 2048, FULL = 65535;
    localparam int M_IDLE = 0, M_ATK = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

    int          m_st, m_lvl;
    bit          m_pend, m_p0, m_vld;
    logic [15:0] m_sout;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Behavioural reference: one call per rising edge, using the inputs
    // presented to the DUT for that edge.
    task automatic model_edge();
        longint p;
        bit     pend;
        if (rst) begin
            m_st = M_IDLE; m_lvl = 0; m_pend = 0; m_p0 = 0; m_vld = 0; m_sout = 16'd0;
        end else begin
            m_vld = m_p0;
            if (m_p0) begin
                p = longint'($signed(sin)) * longint'(m_lvl);
                m_sout = 16'(p >>> 16);
            end
            m_p0 = tick;
            pend = m_pend || trig;
            if (!tick) begin
                m_pend = pend;
            end else begin
                m_pend = 0;
                if (pend) m_st = M_ATK;
                else if (m_st == M_ATK) begin
                    if (!gate) m_st = M_REL;
                    else begin
                        m_lvl = (m_lvl + A_STEP > FULL) ? FULL : m_lvl + A_STEP;
                        if (m_lvl == FULL) m_st = M_DEC;
                    end
                end else if (m_st == M_DEC) begin
                    if (!gate) m_st = M_REL;
                    else begin
                        m_lvl = (m_lvl - D_STEP < SUS) ? SUS : m_lvl - D_STEP;
                        if (m_lvl == SUS) m_st = M_SUS;
                    end
                end else if (m_st == M_SUS) begin
                    if (!gate) m_st = M_REL;
                end else if (m_st == M_REL) begin
                    m_lvl = (m_lvl - R_STEP < 0) ? 0 : m_lvl - R_STEP;
                    if (m_lvl == 0) m_st = M_IDLE;
                end else begin
                    m_lvl = 0;
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit tk, input bit g, input bit tr, input logic [15:0] s);
        rst = r; tick = tk; gate = g; trig = tr; sin = s;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic ticks(input int n, input bit g, input logic [15:0] s);
        repeat (n) begin
            cyc(0, 1, g, 0, s);
            cyc(0, 0, g, 0, s);
            cyc(0, 0, g, 0, s);
        end
    endtask

    task automatic test_reset();
        repeat (4) cyc(1, 1, 1, 1, 16'($urandom));
        n_checks++; if (lvl !== 16'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", lvl); end
        n_checks++; if (act !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", act); end
        n_checks++; if (svld !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", svld); end
        n_checks++; if (sout !== 16'd0) begin n_fail++; $display("FAIL reset_sample: got %h want 0000", sout); end
        n_checks++; if (dc !== 8'd128) begin n_fail++; $display("FAIL reset_dc: got %0d want 128", dc); end
        cyc(0, 0, 1, 0, 16'd0);
        n_checks++; if (act !== 1'b0) begin n_fail++; $display("FAIL reset_release_active: got %b want 0", act); end
    endtask

    task automatic test_adsr();
        cyc(0, 0, 1, 1, 16'h4000);
        cyc(0, 0, 1, 0, 16'h4000);
        ticks(1, 1, 16'h4000);
        n_checks++; if (act !== 1'b1 || lvl !== 16'd0) begin n_fail++; $display("FAIL adsr_start: got act=%b lvl=%0d want act=1 lvl=0", act, lvl); end
        ticks(15, 1, 16'h4000);
        n_checks++; if (lvl !== 16'd61440) begin n_fail++; $display("FAIL adsr_tick15: got %0d want 61440", lvl); end
        ticks(1, 1, 16'h4000);
        n_checks++; if (lvl !== 16'd65535) begin n_fail++; $display("FAIL adsr_peak: got %0d want 65535", lvl); end
        ticks(31, 1, 16'h4000);
        n_checks++; if (lvl !== 16'd33791) begin n_fail++; $display("FAIL adsr_tick47: got %0d want 33791", lvl); end
        ticks(1, 1, 16'h4000);
        n_checks++; if (lvl !== 16'd32768) begin n_fail++; $display("FAIL adsr_sustain: got %0d want 32768", lvl); end
        ticks(5, 1, 16'h4000);
        n_checks++; if (lvl !== 16'd32768 || act !== 1'b1) begin n_fail++; $display("FAIL adsr_hold: got lvl=%0d act=%b want 32768/1", lvl, act); end
        n_checks++; if (sout !== 16'h2000) begin n_fail++; $display("FAIL adsr_sample: got %h want 2000", sout); end
        n_checks++; if (dc !== 8'hA0) begin n_fail++; $display("FAIL adsr_dc: got %h want a0", dc); end
    endtask

    task automatic test_release();
        ticks(1, 0, 16'h4000);
        n_checks++; if (lvl !== 16'd32768 || act !== 1'b1) begin n_fail++; $display("FAIL rel_start: got lvl=%0d act=%b want 32768/1", lvl, act); end
        ticks(15, 0, 16'h4000);
        n_checks++; if (lvl !== 16'd2048 || act !== 1'b1) begin n_fail++; $display("FAIL rel_tick15: got lvl=%0d act=%b want 2048/1", lvl, act); end
        ticks(1, 0, 16'h4000);
        n_checks++; if (lvl !== 16'd0 || act !== 1'b0) begin n_fail++; $display("FAIL rel_end: got lvl=%0d act=%b want 0/0", lvl, act); end
        n_checks++; if (dc !== 8'd128 || sout !== 16'd0) begin n_fail++; $display("FAIL rel_out: got dc=%0d s=%h want 128/0000", dc, sout); end
        ticks(2, 1, 16'h4000);
        n_checks++; if (act !== 1'b0) begin n_fail++; $display("FAIL rel_gate_no_restart: got %b want 0", act); end
    endtask

    task automatic test_retrigger();
        cyc(1, 0, 1, 0, 16'h1234);
        cyc(0, 0, 1, 1, 16'h1234);
        ticks(49, 1, 16'h1234);
        ticks(1, 0, 16'h1234);
        ticks(8, 0, 16'h1234);
        n_checks++; if (lvl !== 16'd16384) begin n_fail++; $display("FAIL retrig_pre: got %0d want 16384", lvl); end
        cyc(0, 0, 1, 1, 16'h1234);
        ticks(1, 1, 16'h1234);
        n_checks++; if (lvl !== 16'd16384 || act !== 1'b1) begin n_fail++; $display("FAIL retrig_tick: got lvl=%0d act=%b want 16384/1", lvl, act); end
        ticks(1, 1, 16'h1234);
        n_checks++; if (lvl !== 16'd20480) begin n_fail++; $display("FAIL retrig_step: got %0d want 20480", lvl); end
        ticks(10, 1, 16'h1234);
        n_checks++; if (lvl !== 16'd61440) begin n_fail++; $display("FAIL retrig_tick11: got %0d want 61440", lvl); end
        ticks(1, 1, 16'h1234);
        n_checks++; if (lvl !== 16'd65535) begin n_fail++; $display("FAIL retrig_peak: got %0d want 65535", lvl); end
    endtask

    task automatic test_same_cycle();
        cyc(1, 0, 0, 0, 16'h0100);
        cyc(0, 1, 0, 1, 16'h0100);
        n_checks++; if (act !== 1'b1 || lvl !== 16'd0) begin n_fail++; $display("FAIL same_attack: got act=%b lvl=%0d want 1/0", act, lvl); end
        cyc(0, 0, 0, 0, 16'h0100);
        ticks(1, 0, 16'h0100);
        n_checks++; if (act !== 1'b1 || lvl !== 16'd0) begin n_fail++; $display("FAIL same_release: got act=%b lvl=%0d want 1/0", act, lvl); end
        ticks(1, 0, 16'h0100);
        n_checks++; if (act !== 1'b0) begin n_fail++; $display("FAIL same_idle: got %b want 0", act); end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 1, 0, 16'h4000);
        cyc(0, 0, 1, 1, 16'h4000);
        ticks(20, 1, 16'h4000);
        n_checks++; if (lvl !== 16'd62463 || sout === 16'd0) begin n_fail++; $display("FAIL mid_decay: got lvl=%0d s=%h want 62463/nonzero", lvl, sout); end
        cyc(0, 1, 1, 0, 16'h4000);
        cyc(1, 0, 1, 0, 16'h4000);
        n_checks++; if (lvl !== 16'd0 || act !== 1'b0) begin n_fail++; $display("FAIL mid_reset_state: got lvl=%0d act=%b want 0/0", lvl, act); end
        n_checks++; if (sout !== 16'd0 || dc !== 8'd128 || svld !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out: got s=%h dc=%0d v=%b want 0000/128/0", sout, dc, svld); end
        cyc(0, 0, 1, 0, 16'h4000);
        n_checks++; if (svld !== 1'b0 || act !== 1'b0) begin n_fail++; $display("FAIL mid_no_valid: got v=%b act=%b want 0/0", svld, act); end
    endtask

    task automatic test_bound();
        cyc(1, 0, 1, 0, 16'h8000);
        cyc(0, 0, 1, 1, 16'h8000);
        ticks(17, 1, 16'h8000);
        n_checks++; if (lvl !== 16'd65535) begin n_fail++; $display("FAIL bound_level: got %0d want 65535", lvl); end
        n_checks++; if (sout !== 16'h8000) begin n_fail++; $display("FAIL bound_sample: got %h want 8000", sout); end
        n_checks++; if (dc !== 8'd0) begin n_fail++; $display("FAIL bound_dc: got %0d want 0", dc); end
    endtask

    task automatic test_random();
        bit          g;
        logic [7:0]  edc;
        int          vld_count;
        cyc(1, 0, 1, 0, 16'd0);
        g = 1;
        vld_count = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) g = ~g;
            cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 2) == 0), g,
                ($urandom_range(0, 79) == 0), 16'($urandom));
            edc = m_sout[15:8] + 8'd128;
            n_checks++; if (lvl !== 16'(m_lvl)) begin n_fail++; $display("FAIL rand_level[%0d]: got %0d want %0d", i, lvl, m_lvl); end
            n_checks++; if (act !== (m_st != M_IDLE)) begin n_fail++; $display("FAIL rand_active[%0d]: got %b want %b", i, act, m_st != M_IDLE); end
            n_checks++; if (svld !== m_vld) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", i, svld, m_vld); end
            n_checks++; if (sout !== m_sout) begin n_fail++; $display("FAIL rand_sample[%0d]: got %h want %h", i, sout, m_sout); end
            n_checks++; if (dc !== edc) begin n_fail++; $display("FAIL rand_dc[%0d]: got %0d want %0d", i, dc, edc); end
            if (svld === 1'b1) vld_count++;
        end
        n_checks++; if (vld_count < 100) begin n_fail++; $display("FAIL rand_activity: got %0d valid pulses want >=100", vld_count); end
    endtask

    initial begin
        rst = 1; tick = 0; gate = 0; trig = 0; sin = 16'd0;
        @(negedge clk);
        test_reset();
        test_adsr();
        test_release();
        test_retrigger();
        test_same_cycle();
        test_reset_mid();
        test_bound();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
